// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority vote, break detect and an
// error-tagged FWFT RX FIFO with level, threshold and idle timeout.

module sync_fifo_fwft_with_clear #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 11,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full,
    output logic [LVL_W-1:0] o_level,
    output logic             o_overflow,
    output logic             o_underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LVL_W-1:0] level;
    logic             wr_ok;
    logic             rd_ok;

    assign o_empty   = (level == '0);
    assign o_full    = (level == FULL_LVL);
    assign o_level   = level;
    assign o_rd_data = mem[rd_ptr];

    // clear wins over both ports in its cycle
    assign wr_ok = i_wr_en & ~o_full & ~i_clear;
    assign rd_ok = i_rd_en & ~o_empty & ~i_clear;

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            o_overflow  <= i_wr_en & o_full & ~i_clear;
            o_underflow <= i_rd_en & o_empty & ~i_clear;
            if (i_clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
                if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
                unique case ({wr_ok, rd_ok})
                    2'b10:   level <= level + LVL_W'(1);
                    2'b01:   level <= level - LVL_W'(1);
                    default: level <= level;
                endcase
            end
        end
    end
endmodule

module uart_rx_os #(
    parameter int FIFO_DEPTH   = 16,
    parameter int OVERSAMPLE   = 16,
    parameter int TIMEOUT_BITS = 40,
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_os_tick,
    input  logic             i_uart_rx,
    input  logic [1:0]       i_data_bits,
    input  logic             i_use_parity,
    input  logic             i_parity,
    input  logic             i_stop_bits,
    input  logic [LVL_W-1:0] i_threshold,
    input  logic             i_fifo_clear,
    input  logic             i_fifo_rd_en,
    output logic [7:0]       o_fifo_rd_data,
    output logic [2:0]       o_fifo_rd_err,
    output logic             o_fifo_empty,
    output logic             o_fifo_full,
    output logic [LVL_W-1:0] o_fifo_level,
    output logic             o_threshold,
    output logic             o_timeout,
    output logic             o_overflow_error,
    output logic             o_underflow_error
);
    localparam int CNT_W  = $clog2(OVERSAMPLE);
    localparam int MID    = OVERSAMPLE / 2;
    localparam int TO_LIM = TIMEOUT_BITS * OVERSAMPLE;
    localparam int TO_W   = $clog2(TO_LIM + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_STOP2, S_BRK
    } state_t;

    state_t state, state_nx;

    logic             rx_s1, rx_s2;
    logic             smp_a, smp_b;
    logic [CNT_W-1:0] os_cnt;
    logic             vote;
    logic             dec;
    logic             bend;
    logic [7:0]       data;
    logic [2:0]       bit_idx;
    logic             last_bit;
    logic             par_err;
    logic             frm_err;
    logic             all_zero;
    logic [1:0]       cfg_bits;
    logic             cfg_par_en;
    logic             cfg_par;
    logic             cfg_stop2;
    logic             exp_par;
    logic             start_go;
    logic             last_stop;
    logic             brk_now;
    logic             wr_vld;
    logic [10:0]      wr_word;
    logic [10:0]      head;
    logic [TO_W-1:0]  to_cnt;
    logic             to_evt;

    assign vote = (smp_a & smp_b) | (smp_a & rx_s2) | (smp_b & rx_s2);
    assign dec  = i_os_tick & (os_cnt == CNT_W'(MID + 1));
    assign bend = i_os_tick & (os_cnt == CNT_W'(OVERSAMPLE - 1));
    assign last_bit = (bit_idx == ({1'b0, cfg_bits} + 3'd4));
    assign exp_par  = ^data ^ cfg_par;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            smp_a <= 1'b1;
            smp_b <= 1'b1;
        end else begin
            rx_s1 <= i_uart_rx;
            rx_s2 <= rx_s1;
            if (i_os_tick && os_cnt == CNT_W'(MID - 1)) smp_a <= rx_s2;
            if (i_os_tick && os_cnt == CNT_W'(MID))     smp_b <= rx_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (start_go) state_nx = S_START;
            S_START: begin
                if (dec && vote) state_nx = S_IDLE;
                else if (bend)   state_nx = S_DATA;
            end
            S_DATA: begin
                if (bend && last_bit)
                    state_nx = cfg_par_en ? S_PAR : S_STOP;
            end
            S_PAR:   if (bend) state_nx = S_STOP;
            S_STOP: begin
                if (last_stop)
                    state_nx = brk_now ? S_BRK : S_IDLE;
                else if (bend && cfg_stop2)
                    state_nx = S_STOP2;
            end
            S_STOP2: begin
                if (last_stop)
                    state_nx = brk_now ? S_BRK : S_IDLE;
            end
            S_BRK:   if (dec && vote) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        start_go  = (state == S_IDLE) & i_os_tick & ~rx_s2;
        last_stop = dec & (((state == S_STOP) & ~cfg_stop2)
                         | (state == S_STOP2));
        brk_now   = last_stop & all_zero & ~vote;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            os_cnt <= '0;
        end else if (state_nx == S_IDLE && state != S_IDLE) begin
            os_cnt <= '0;
        end else if (state == S_IDLE) begin
            os_cnt <= start_go ? CNT_W'(1) : '0;
        end else if (i_os_tick) begin
            os_cnt <= bend ? '0 : os_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data       <= '0;
            bit_idx    <= '0;
            par_err    <= 1'b0;
            frm_err    <= 1'b0;
            all_zero   <= 1'b0;
            cfg_bits   <= '0;
            cfg_par_en <= 1'b0;
            cfg_par    <= 1'b0;
            cfg_stop2  <= 1'b0;
            wr_vld     <= 1'b0;
            wr_word    <= '0;
        end else begin
            wr_vld <= 1'b0;
            if (start_go) begin
                data       <= '0;
                bit_idx    <= '0;
                par_err    <= 1'b0;
                frm_err    <= 1'b0;
                all_zero   <= 1'b1;
                cfg_bits   <= i_data_bits;
                cfg_par_en <= i_use_parity;
                cfg_par    <= i_parity;
                cfg_stop2  <= i_stop_bits;
            end
            if (dec) begin
                unique case (state)
                    S_DATA: begin
                        data[bit_idx] <= vote;
                        all_zero      <= all_zero & ~vote;
                    end
                    S_PAR: begin
                        par_err  <= (vote != exp_par);
                        all_zero <= all_zero & ~vote;
                    end
                    S_STOP: begin
                        frm_err  <= frm_err | ~vote;
                        all_zero <= all_zero & ~vote;
                    end
                    S_STOP2: frm_err <= frm_err | ~vote;
                    default: ;
                endcase
            end
            if (bend && state == S_DATA && !last_bit)
                bit_idx <= bit_idx + 3'd1;
            // break overrides parity/frame with a fixed tag
            if (last_stop) begin
                wr_vld  <= 1'b1;
                wr_word <= brk_now ? 11'b110_0000_0000
                         : {1'b0, frm_err | ~vote, par_err, data};
            end
        end
    end

    sync_fifo_fwft_with_clear #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (11),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (i_fifo_clear),
        .i_wr_en     (wr_vld),
        .i_wr_data   (wr_word),
        .i_rd_en     (i_fifo_rd_en),
        .o_rd_data   (head),
        .o_empty     (o_fifo_empty),
        .o_full      (o_fifo_full),
        .o_level     (o_fifo_level),
        .o_overflow  (o_overflow_error),
        .o_underflow (o_underflow_error)
    );

    assign o_fifo_rd_data = head[7:0];
    assign o_fifo_rd_err  = head[10:8];

    assign to_evt = wr_vld | i_fifo_clear
                  | (i_fifo_rd_en & ~o_fifo_empty);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt      <= '0;
            o_timeout   <= 1'b0;
            o_threshold <= 1'b0;
        end else begin
            o_threshold <= (o_fifo_level >= i_threshold);
            o_timeout   <= ~to_evt & (to_cnt == TO_W'(TO_LIM));
            if (to_evt)
                to_cnt <= '0;
            else if (i_os_tick && state == S_IDLE
                     && !o_fifo_empty && to_cnt != TO_W'(TO_LIM))
                to_cnt <= to_cnt + TO_W'(1);
        end
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: framing, voting, break, FIFO
// status, overflow/underflow, threshold, timeout and clear.

module tb_uart_rx_os;
    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       os_tick;
    logic       uart_rx;
    logic [1:0] data_bits;
    logic       use_parity;
    logic       parity;
    logic       stop_bits;
    logic [4:0] threshold;
    logic       fifo_clear;
    logic       fifo_rd_en;
    logic [7:0] rd_data;
    logic [2:0] rd_err;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       thr;
    logic       timeout;
    logic       ovf;
    logic       ufl;

    int n_chk  = 0;
    int n_fail = 0;
    int ovf_cnt = 0;
    int ufl_cnt = 0;

    uart_rx_os dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_os_tick         (os_tick),
        .i_uart_rx         (uart_rx),
        .i_data_bits       (data_bits),
        .i_use_parity      (use_parity),
        .i_parity          (parity),
        .i_stop_bits       (stop_bits),
        .i_threshold       (threshold),
        .i_fifo_clear      (fifo_clear),
        .i_fifo_rd_en      (fifo_rd_en),
        .o_fifo_rd_data    (rd_data),
        .o_fifo_rd_err     (rd_err),
        .o_fifo_empty      (empty),
        .o_fifo_full       (full),
        .o_fifo_level      (level),
        .o_threshold       (thr),
        .o_timeout         (timeout),
        .o_overflow_error  (ovf),
        .o_underflow_error (ufl)
    );

    always #5 clk = ~clk;

    initial begin
        os_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            os_tick = 1'b1;
            @(negedge clk);
            os_tick = 1'b0;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (ovf) ovf_cnt++;
            if (ufl) ufl_cnt++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [15:0] bits, input int n,
                              input int g);
        for (int i = 0; i < n; i++) begin
            if (i == g) begin
                uart_rx = bits[i];
                wait_clk(28);
                uart_rx = ~bits[i];
                wait_clk(4);
                uart_rx = bits[i];
                wait_clk(32);
            end else begin
                uart_rx = bits[i];
                wait_clk(BIT_CLK);
            end
        end
        uart_rx = 1'b1;
    endtask

    task automatic send8(input logic [7:0] d, input int g);
        send_frame({7'h7f, 1'b1, d, 1'b0}, 10, g);
    endtask

    task automatic pop();
        fifo_rd_en = 1'b1;
        @(negedge clk);
        fifo_rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_8n1();
        data_bits  = 2'd3;
        use_parity = 1'b0;
        parity     = 1'b0;
        stop_bits  = 1'b0;
    endtask

    initial begin
        int seen;
        rst_n      = 1'b0;
        uart_rx    = 1'b1;
        threshold  = 5'd4;
        fifo_clear = 1'b0;
        fifo_rd_en = 1'b0;
        set_8n1();
        wait_clk(5);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_empty", int'(empty), 1);
        check("rst_level", int'(level), 0);
        check("rst_full", int'(full), 0);
        check("rst_thr", int'(thr), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_ufl", int'(ufl), 0);

        pop();
        check("ufl_pulse", ufl_cnt, 1);
        check("ufl_level", int'(level), 0);

        send8(8'hA5, -1);
        wait_clk(BIT_CLK);
        check("a5_level", int'(level), 1);
        check("a5_data", int'(rd_data), 'hA5);
        check("a5_err", int'(rd_err), 0);
        pop();
        check("a5_pop_empty", int'(empty), 1);

        send8(8'h3C, 3);
        wait_clk(BIT_CLK);
        check("glitch_data", int'(rd_data), 'h3C);
        check("glitch_err", int'(rd_err), 0);
        pop();

        data_bits  = 2'd0;
        use_parity = 1'b1;
        parity     = 1'b0;
        stop_bits  = 1'b1;
        send_frame({7'h7f, 1'b1, 1'b1, 1'b0, 5'h13, 1'b0}, 9, -1);
        wait_clk(BIT_CLK);
        send_frame({7'h7f, 1'b0, 1'b1, 1'b0, 5'h13, 1'b0}, 9, -1);
        wait_clk(2 * BIT_CLK);
        check("5e2_level", int'(level), 2);
        check("5e2_par_data", int'(rd_data), 'h13);
        check("5e2_par_err", int'(rd_err), 3'b001);
        pop();
        check("5e2_frm_data", int'(rd_data), 'h13);
        check("5e2_frm_err", int'(rd_err), 3'b011);
        pop();
        check("5e2_drain", int'(level), 0);
        set_8n1();

        uart_rx = 1'b0;
        wait_clk(16);
        uart_rx = 1'b1;
        wait_clk(2 * BIT_CLK);
        check("short_level", int'(level), 0);
        send8(8'h5A, -1);
        wait_clk(BIT_CLK);
        check("short_after_data", int'(rd_data), 'h5A);
        check("short_after_lvl", int'(level), 1);
        pop();

        uart_rx = 1'b0;
        wait_clk(12 * BIT_CLK);
        check("brk_level_low", int'(level), 1);
        check("brk_data", int'(rd_data), 0);
        check("brk_err", int'(rd_err), 3'b110);
        uart_rx = 1'b1;
        wait_clk(3 * BIT_CLK);
        check("brk_level_high", int'(level), 1);
        pop();

        send8(8'h11, -1);
        wait_clk(600 * 4);
        check("to_early", int'(timeout), 0);
        wait_clk(60 * 4);
        check("to_set", int'(timeout), 1);
        check("to_data", int'(rd_data), 'h11);
        pop();
        check("to_clr_read", int'(timeout), 0);

        for (int i = 0; i < 3; i++) begin
            send8(8'(8'h40 + i), -1);
            wait_clk(BIT_CLK);
        end
        check("thr_lvl3", int'(thr), 0);
        seen = 0;
        fork
            send8(8'h43, -1);
            begin
                for (int k = 0; k < 2000 && seen == 0; k++) begin
                    @(negedge clk);
                    if (level == 5'd4) seen = 1;
                end
            end
        join
        check("thr_wait", seen, 1);
        wait_clk(BIT_CLK);
        check("thr_rise", int'(thr), 1);

        for (int i = 4; i < 17; i++) begin
            send8(8'(8'h40 + i), -1);
            wait_clk(BIT_CLK);
        end
        check("ovf_level", int'(level), 16);
        check("ovf_full", int'(full), 1);
        check("ovf_pulses", ovf_cnt, 1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain%0d", i), int'(rd_data), 'h40 + i);
            pop();
        end
        check("drain_empty", int'(empty), 1);
        check("drain_ufl", ufl_cnt, 1);

        send8(8'h60, -1);
        wait_clk(BIT_CLK);
        check("clr_pre_level", int'(level), 1);
        fork
            send8(8'h61, -1);
            begin
                wait_clk(9 * BIT_CLK);
                fifo_clear = 1'b1;
                wait_clk(2 * BIT_CLK);
                fifo_clear = 1'b0;
            end
        join
        wait_clk(2);
        check("clr_level", int'(level), 0);
        check("clr_empty", int'(empty), 1);
        check("clr_no_ovf", ovf_cnt, 1);
        check("clr_timeout", int'(timeout), 0);
        send8(8'h62, -1);
        wait_clk(BIT_CLK);
        check("clr_after_data", int'(rd_data), 'h62);
        check("clr_after_lvl", int'(level), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
